// File: rtl/shift_register.sv
// Word-wide delay line: DEPTH enabled shifts carry dataIn to dataOut.
// Optional fill-status output `valid` is compiled in with SHIFT_REGISTER_VALID_EN.
module shift_register #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] dataOut
`ifdef SHIFT_REGISTER_VALID_EN
    ,
    output logic             valid
`endif
);

    if (DEPTH < 1 || DEPTH > 64) begin : g_depth_check
        $error("shift_register: DEPTH must be in 1..64");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        if (enable) begin
            stage_d[0] = dataIn;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // Output is the oldest stage; no path from dataIn/enable reaches it combinationally.
    assign dataOut = stage_q[DEPTH-1];

`ifdef SHIFT_REGISTER_VALID_EN
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             valid_q;

    // Saturates once every stage has been written from dataIn since reset.
    always_comb begin
        cnt_d = cnt_q;
        if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= (cnt_d == CNT_MAX);
        end
    end

    assign valid = valid_q;
`endif

endmodule

// File: tb/tb_shift_register.sv
// Randomized and directed bench for shift_register (DEPTH=4 and DEPTH=1 instances)
// checked against a queue-based delay-line reference.
module tb_shift_register;

    localparam int W  = 8;
    localparam int D  = 4;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [W-1:0] dataIn;
    logic [W-1:0] dataOut;
    logic [W-1:0] dataOut1;
`ifdef SHIFT_REGISTER_VALID_EN
    logic         valid;
    logic         valid1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference: exp_q[0] is the newest word, exp_q[D-1] the oldest.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp1;
    int           shifts;

    shift_register #(.WIDTH(W), .DEPTH(D)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .dataIn (dataIn),
        .dataOut(dataOut)
`ifdef SHIFT_REGISTER_VALID_EN
        ,
        .valid  (valid)
`endif
    );

    shift_register #(.WIDTH(W), .DEPTH(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .dataIn (dataIn),
        .dataOut(dataOut1)
`ifdef SHIFT_REGISTER_VALID_EN
        ,
        .valid  (valid1)
`endif
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        for (int i = 0; i < D; i++) exp_q.push_back('0);
        exp1   = '0;
        shifts = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, "_out"}, 32'(dataOut), 32'(exp_q[D-1]));
        check({tag, "_out1"}, 32'(dataOut1), 32'(exp1));
`ifdef SHIFT_REGISTER_VALID_EN
        check({tag, "_valid"}, 32'(valid), 32'(shifts >= D));
        check({tag, "_valid1"}, 32'(valid1), 32'(shifts >= 1));
`endif
    endtask

    // Drive one cycle, let the edge happen, then compare just after it.
    task automatic step(input logic en, input logic [W-1:0] din, input string tag);
        enable = en;
        dataIn = din;
        @(posedge clk);
        if (en) begin
            exp_q.push_front(din);
            void'(exp_q.pop_back());
            exp1 = din;
            shifts++;
        end
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse issued mid-cycle; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_clear();
        check({tag, "_async_out"}, 32'(dataOut), 32'h0);
        check({tag, "_async_out1"}, 32'(dataOut1), 32'h0);
`ifdef SHIFT_REGISTER_VALID_EN
        check({tag, "_async_valid"}, 32'(valid), 32'h0);
`endif
        enable = 1'b0;
        dataIn = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] ld[4];
        logic [W-1:0] gap[5];
        int           got_idx;
        logic [W-1:0] prev;

        rst    = 1'b0;
        enable = 1'b0;
        dataIn = '0;
        model_clear();

        // Reset state
        @(posedge clk);
        #1;
        check("reset_out", 32'(dataOut), 32'h0);
        check("reset_out1", 32'(dataOut1), 32'h0);
`ifdef SHIFT_REGISTER_VALID_EN
        check("reset_valid", 32'(valid), 32'h0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Directed load: 15 reaches the output on the 4th enabled edge
        step(1'b1, 8'd15, "load1");
        check("load_e1", 32'(dataOut), 32'h0);
        check("d1_next", 32'(dataOut1), 32'd15);
        step(1'b1, 8'd0, "load2");
        check("load_e2", 32'(dataOut), 32'h0);
        step(1'b1, 8'd0, "load3");
        check("load_e3", 32'(dataOut), 32'h0);
        step(1'b1, 8'd0, "load4");
        check("load_e4", 32'(dataOut), 32'd15);

        // Hold
        ld[0] = 8'hA5; ld[1] = 8'h3C; ld[2] = 8'h7E; ld[3] = 8'h01;
        for (int i = 0; i < 4; i++) step(1'b1, ld[i], "hold_load");
        check("hold_loaded", 32'(dataOut), 32'hA5);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, W'($urandom_range(0, 255)), "hold");
            check("hold_a5", 32'(dataOut), 32'hA5);
        end
        for (int i = 1; i < 4; i++) begin
            step(1'b1, W'($urandom_range(0, 255)), "rehold");
            check("reenable_seq", 32'(dataOut), 32'(ld[i]));
        end

        // Async reset mid-operation
        async_reset("mid");

        // Gapped enable: 1..5 on alternate cycles, then flush with zeros
        for (int i = 0; i < 5; i++) gap[i] = W'(i + 1);
        got_idx = 0;
        prev    = dataOut;
        for (int i = 0; i < 5 + D; i++) begin
            step(1'b1, (i < 5) ? gap[i] : 8'h0, "gap_en");
            if (dataOut != prev && got_idx < 5) begin
                check("gap_order", 32'(dataOut), 32'(gap[got_idx]));
                check("gap_latency", 32'(i), 32'(got_idx + D - 1));
                got_idx++;
            end
            prev = dataOut;
            step(1'b0, W'($urandom_range(0, 255)), "gap_dis");
        end
        check("gap_count", 32'(got_idx), 32'd5);

        // Random with a mid-run reset pulse
        for (int i = 0; i < 5000; i++) begin
            if (i == 2500) async_reset("rand");
            step(1'($urandom_range(0, 1)), W'($urandom()), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
